// File: rtl/serial_word_receiver_if.sv
// Bundle of signals between serial_word_receiver and its surroundings.
//   serial_in   : serial line into the receiver, idle high
//   out_ready   : consumer accepts the head word this cycle
//   out_data    : FIFO head word, valid while out_valid=1 (0 when empty)
//   out_valid   : FIFO non-empty
//   fifo_count  : number of buffered words
//   frame_error : 1-cycle pulse, stop bit sampled low
//   overflow    : 1-cycle pulse, good frame dropped because FIFO full
//   HEX0        : active-low seven-segment {g,f,e,d,c,b,a} of the head word
// Modports: master = line driver / consumer side, slave = receiver side.
interface serial_word_receiver_if #(
  parameter int unsigned WORD_SIZE  = 4,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  logic                 serial_in;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_valid;
  logic [CountW-1:0]    fifo_count;
  logic                 frame_error;
  logic                 overflow;
  logic [6:0]           HEX0;

  modport master (
    output serial_in, out_ready,
    input  out_data, out_valid, fifo_count, frame_error, overflow, HEX0
  );

  modport slave (
    input  serial_in, out_ready,
    output out_data, out_valid, fifo_count, frame_error, overflow, HEX0
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial word receiver: deserialises frames (start 0, WORD_SIZE data bits LSB first, stop 1,
// each bit BIT_CYCLES clocks) from an asynchronous line, buffers good words in a FIFO with a
// valid/ready pop port and shows the head word on a seven-segment display.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : serial_word_receiver_if slave modport (line in, FIFO pop port, status, HEX0)
module serial_word_receiver #(
  parameter int unsigned WORD_SIZE  = 4,
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  serial_word_receiver_if.slave bus
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(BIT_CYCLES);
  localparam int unsigned BitW   = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  localparam logic [CntW-1:0]   HalfLast = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0]   FullLast = CntW'(BIT_CYCLES - 1);
  localparam logic [BitW-1:0]   LastBit  = BitW'(WORD_SIZE - 1);
  localparam logic [CountW-1:0] Full     = CountW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Line synchroniser
  logic [1:0] sync_q;
  logic       rx;

  // Frame FSM
  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [BitW-1:0]      bit_idx_q;
  logic [WORD_SIZE-1:0] shift_q;
  logic                 frame_error_q;
  logic                 stop_done;
  logic                 push;

  // FIFO
  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]    count_q, count_d;
  logic                 empty, full, pop, wr_en, overflow_q;
  logic [WORD_SIZE-1:0] head;
  logic [3:0]           nibble;
  logic [6:0]           hex_q;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Idle-high reset value so a reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.serial_in};
    end
  end

  assign rx = sync_q[1];

  // The stop bit is sampled on the edge that leaves StStop; the word is pushed on that same edge.
  assign stop_done = (state_q == StStop) && (cnt_q == FullLast);
  assign push      = stop_done && rx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            state_q   <= rx ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == FullLast) begin
            cnt_q   <= '0;
            shift_q <= (shift_q >> 1) | (WORD_SIZE'(rx) << (WORD_SIZE - 1));
            if (bit_idx_q == LastBit) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + BitW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == FullLast) begin
            cnt_q         <= '0;
            state_q       <= StIdle;
            frame_error_q <= !rx;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == Full);
  assign pop   = !empty && bus.out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CountW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // Storage is not reset, so the head is masked to keep out_data at 0 while empty.
  assign head   = empty ? '0 : mem_q[rd_ptr_q];
  assign nibble = 4'(head);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hex_q      <= 7'h7F;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q    <= count_d;
      overflow_q <= push && full && !pop;
      hex_q      <= empty ? 7'h7F : seg7(nibble);
    end
  end

  assign bus.out_data    = head;
  assign bus.out_valid   = !empty;
  assign bus.fifo_count  = count_q;
  assign bus.frame_error = frame_error_q;
  assign bus.overflow    = overflow_q;
  assign bus.HEX0        = hex_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: directed frames, a queue-based reference model checked every
// cycle, plus hand-computed literal expectations at the key points of each scenario.
module tb_serial_word_receiver;
  localparam int WS    = 4;
  localparam int BC    = 4;
  localparam int DEPTH = 8;
  // Start-bit edge to push edge: 2 synchroniser clocks + 1 idle detect, half a start bit,
  // the data bits, then one full stop bit.
  localparam int LAT   = 3 + BC / 2 + WS * BC + BC;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  serial_word_receiver_if #(.WORD_SIZE(WS), .FIFO_DEPTH(DEPTH)) bus ();

  serial_word_receiver #(
    .WORD_SIZE (WS),
    .BIT_CYCLES(BC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    int         due;
    logic [3:0] w;
    bit         ok;
  } ev_t;

  ev_t        evq [$];
  ev_t        ev_m;
  logic [3:0] mq [$];
  logic [6:0] exp_hex = 7'h7F;
  bit         exp_fe  = 1'b0;
  bit         exp_ov  = 1'b0;
  bit         pop_m;
  int         cyc     = 0;
  int         n_cmp   = 0;
  int         n_fail  = 0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model, advanced on each rising edge from the pre-edge inputs.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      mq.delete();
      evq.delete();
      exp_hex = 7'h7F;
      exp_fe  = 1'b0;
      exp_ov  = 1'b0;
    end else begin
      pop_m   = (mq.size() > 0) && bus.out_ready;
      exp_hex = (mq.size() > 0) ? glyph[mq[0]] : 7'h7F;
      exp_fe  = 1'b0;
      exp_ov  = 1'b0;
      if (pop_m) void'(mq.pop_front());
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev_m = evq.pop_front();
        if (!ev_m.ok) exp_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(ev_m.w);
        else exp_ov = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    check("m_valid", bus.out_valid, mq.size() > 0);
    check("m_data", bus.out_data, (mq.size() > 0) ? mq[0] : 4'h0);
    check("m_count", bus.fifo_count, mq.size());
    check("m_ferr", bus.frame_error, exp_fe);
    check("m_ovf", bus.overflow, exp_ov);
    check("m_hex", bus.HEX0, exp_hex);
    if (bus.frame_error) fe_cnt++;
    if (bus.overflow) ov_cnt++;
  end

  // Called at a negedge; drives nbits bits (6 = whole frame) of {stop, w, start}, LSB first.
  task automatic send_frame(input logic [3:0] w, input bit stop_ok, input int nbits);
    logic [5:0] bits;
    bits = {stop_ok, w, 1'b0};
    if (nbits == 6) evq.push_back('{due: cyc + LAT, w: w, ok: stop_ok});
    for (int i = 0; i < nbits; i++) begin
      bus.serial_in = bits[i];
      repeat (BC) @(negedge clock);
    end
    bus.serial_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  int fe_base, ov_base;

  initial begin
    bus.serial_in = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", bus.out_valid, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_hex", bus.HEX0, 7'h7F);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single frame 0x5
    send_frame(4'h5, 1'b1, 6);
    repeat (3) @(negedge clock);
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, 4'h5);
    check("t1_count", bus.fifo_count, 1);
    check("t1_hex", bus.HEX0, 7'b0010010);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;

    // Back-to-back frames, then drain
    send_frame(4'h1, 1'b1, 6);
    send_frame(4'h2, 1'b1, 6);
    send_frame(4'h3, 1'b1, 6);
    repeat (3) @(negedge clock);
    check("t2_count", bus.fifo_count, 3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_seq", bus.out_data, i + 1);
      @(negedge clock);
    end
    bus.out_ready = 1'b0;
    check("t2_valid", bus.out_valid, 0);
    @(negedge clock);
    check("t2_hex", bus.HEX0, 7'h7F);

    // Bad stop bit
    fe_base = fe_cnt;
    send_frame(4'hA, 1'b0, 6);
    repeat (10) @(negedge clock);
    check("t3_ferr_pulses", fe_cnt - fe_base, 1);
    check("t3_count", bus.fifo_count, 0);

    // Overflow: nine frames into an eight-deep FIFO
    ov_base = ov_cnt;
    for (int i = 0; i < 9; i++) send_frame(4'(i * 3 + 1), 1'b1, 6);
    repeat (3) @(negedge clock);
    check("t4_count", bus.fifo_count, 8);
    check("t4_ovf_pulses", ov_cnt - ov_base, 1);
    check("t4_head", bus.out_data, 4'h1);

    // Full FIFO, pop on the push cycle: word accepted
    ov_base = ov_cnt;
    send_frame(4'hE, 1'b1, 6);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("t4b_count", bus.fifo_count, 8);
    check("t4b_ovf_pulses", ov_cnt - ov_base, 0);
    check("t4b_head", bus.out_data, 4'h4);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clock);
    bus.out_ready = 1'b0;
    check("t4b_drained", bus.fifo_count, 3);

    // One-clock glitch on the line
    fe_base = fe_cnt;
    bus.serial_in = 1'b0;
    @(negedge clock);
    bus.serial_in = 1'b1;
    repeat (10) @(negedge clock);
    check("t5_count", bus.fifo_count, 3);
    check("t5_ferr_pulses", fe_cnt - fe_base, 0);

    // Reset mid-DATA with three words buffered
    send_frame(4'h6, 1'b1, 3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_count", bus.fifo_count, 0);
    check("t6_rst_data", bus.out_data, 0);
    check("t6_rst_hex", bus.HEX0, 7'h7F);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    send_frame(4'hF, 1'b1, 6);
    repeat (3) @(negedge clock);
    check("t6_data", bus.out_data, 4'hF);
    check("t6_count", bus.fifo_count, 1);
    check("t6_hex", bus.HEX0, 7'b0001110);
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
